// File: rtl/mem_hier_pkg.sv
// Shared definitions for the dual I/D cache miss controller.
//   state_e   : miss-service FSM encoding (IDLE, WB, RD, FILL)
//   SIDE_I/D  : which cache a captured miss belongs to
//   pick_side : arbitration between simultaneous I and D misses
package mem_hier_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        RD   = 2'd2,
        FILL = 2'd3
    } state_e;

    localparam logic SIDE_I = 1'b0;
    localparam logic SIDE_D = 1'b1;

    // Fixed-priority pick; only meaningful when at least one side misses.
    function automatic logic pick_side(input logic i_miss, input logic d_miss, input logic d_wins);
        logic side;
        if (i_miss && d_miss) begin
            side = d_wins ? SIDE_D : SIDE_I;
        end else if (d_miss) begin
            side = SIDE_D;
        end else begin
            side = SIDE_I;
        end
        return side;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the miss / writeback statistics.
//   clk, rst_n : clock, asynchronous active-low clear
//   inc_i      : count one event this cycle
//   cnt_o      : current count, sticks at all-ones
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: stop at all-ones instead of wrapping to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/dual_cache_miss_ctrl.sv
// Miss controller servicing an I-cache and a D-cache against one unified
// memory. One miss is serviced at a time; a dirty D victim is written back
// before the refill read. Simultaneous misses are resolved by D_FIRST.
//   Inputs : clk, rst_n, I side (i_req, i_hit, i_line_addr),
//            D side (d_req, d_hit, d_dirty, d_line_addr, d_victim_addr,
//            d_victim_data), memory (u_rdata, u_rdy)
//   Outputs: memory request (u_re, u_we, u_addr, u_wdata), refill
//            (fill_data, i_fill_we, d_fill_we), stall, and saturating
//            counters i_miss_cnt, d_miss_cnt, wb_cnt
module dual_cache_miss_ctrl
    import mem_hier_pkg::*;
#(
    parameter int unsigned ADDR_W  = 14,
    parameter int unsigned LINE_W  = 64,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned D_FIRST = 1,
    parameter int unsigned WB_EN   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic              i_hit,
    input  logic [ADDR_W-1:0] i_line_addr,
    input  logic              d_req,
    input  logic              d_hit,
    input  logic              d_dirty,
    input  logic [ADDR_W-1:0] d_line_addr,
    input  logic [ADDR_W-1:0] d_victim_addr,
    input  logic [LINE_W-1:0] d_victim_data,
    input  logic [LINE_W-1:0] u_rdata,
    input  logic              u_rdy,
    output logic              u_re,
    output logic              u_we,
    output logic [ADDR_W-1:0] u_addr,
    output logic [LINE_W-1:0] u_wdata,
    output logic [LINE_W-1:0] fill_data,
    output logic              i_fill_we,
    output logic              d_fill_we,
    output logic              stall,
    output logic [CNT_W-1:0]  i_miss_cnt,
    output logic [CNT_W-1:0]  d_miss_cnt,
    output logic [CNT_W-1:0]  wb_cnt
);

    localparam logic D_WINS  = (D_FIRST != 32'd0) ? 1'b1 : 1'b0;
    localparam logic WB_ALLOW = (WB_EN != 32'd0) ? 1'b1 : 1'b0;

    state_e            state_q, state_d;
    logic              side_q, side_d;
    logic [ADDR_W-1:0] line_addr_q, line_addr_d;
    logic [ADDR_W-1:0] victim_addr_q, victim_addr_d;
    logic [LINE_W-1:0] victim_data_q, victim_data_d;
    logic              u_re_q, u_re_d;
    logic              u_we_q, u_we_d;
    logic [ADDR_W-1:0] u_addr_q, u_addr_d;
    logic [LINE_W-1:0] u_wdata_q, u_wdata_d;
    logic [LINE_W-1:0] fill_data_q, fill_data_d;
    logic              i_fill_we_q, i_fill_we_d;
    logic              d_fill_we_q, d_fill_we_d;

    logic              i_miss_s;
    logic              d_miss_s;
    logic              pick_s;
    logic              i_inc_s;
    logic              d_inc_s;
    logic              wb_inc_s;

    assign i_miss_s = i_req & ~i_hit;
    assign d_miss_s = d_req & ~d_hit;
    assign pick_s   = pick_side(i_miss_s, d_miss_s, D_WINS);

    // FSM next state, miss capture and counter increment strobes.
    always_comb begin
        state_d       = state_q;
        side_d        = side_q;
        line_addr_d   = line_addr_q;
        victim_addr_d = victim_addr_q;
        victim_data_d = victim_data_q;
        fill_data_d   = fill_data_q;
        i_inc_s       = 1'b0;
        d_inc_s       = 1'b0;
        wb_inc_s      = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_miss_s || d_miss_s) begin
                    side_d = pick_s;
                    if (pick_s == SIDE_D) begin
                        line_addr_d   = d_line_addr;
                        victim_addr_d = d_victim_addr;
                        victim_data_d = d_victim_data;
                        d_inc_s       = 1'b1;
                        state_d       = (d_dirty && WB_ALLOW) ? WB : RD;
                    end else begin
                        line_addr_d = i_line_addr;
                        i_inc_s     = 1'b1;
                        state_d     = RD;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WB: begin
                if (u_rdy) begin
                    wb_inc_s = 1'b1;
                    state_d  = RD;
                end else begin
                    state_d = WB;
                end
            end
            RD: begin
                if (u_rdy) begin
                    fill_data_d = u_rdata;
                    state_d     = FILL;
                end else begin
                    state_d = RD;
                end
            end
            FILL: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory/fill outputs are derived from the next state so they can be
    // registered and still line up with the state they belong to.
    always_comb begin
        u_re_d      = (state_d == RD);
        u_we_d      = (state_d == WB);
        i_fill_we_d = (state_d == FILL) && (side_d == SIDE_I);
        d_fill_we_d = (state_d == FILL) && (side_d == SIDE_D);
        u_addr_d    = u_addr_q;
        u_wdata_d   = u_wdata_q;
        if (state_d == WB) begin
            u_addr_d  = victim_addr_d;
            u_wdata_d = victim_data_d;
        end else if (state_d == RD) begin
            u_addr_d  = line_addr_d;
            u_wdata_d = u_wdata_q;
        end else begin
            u_addr_d  = u_addr_q;
            u_wdata_d = u_wdata_q;
        end
    end

    // State, capture and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            side_q        <= SIDE_I;
            line_addr_q   <= {ADDR_W{1'b0}};
            victim_addr_q <= {ADDR_W{1'b0}};
            victim_data_q <= {LINE_W{1'b0}};
            u_re_q        <= 1'b0;
            u_we_q        <= 1'b0;
            u_addr_q      <= {ADDR_W{1'b0}};
            u_wdata_q     <= {LINE_W{1'b0}};
            fill_data_q   <= {LINE_W{1'b0}};
            i_fill_we_q   <= 1'b0;
            d_fill_we_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            side_q        <= side_d;
            line_addr_q   <= line_addr_d;
            victim_addr_q <= victim_addr_d;
            victim_data_q <= victim_data_d;
            u_re_q        <= u_re_d;
            u_we_q        <= u_we_d;
            u_addr_q      <= u_addr_d;
            u_wdata_q     <= u_wdata_d;
            fill_data_q   <= fill_data_d;
            i_fill_we_q   <= i_fill_we_d;
            d_fill_we_q   <= d_fill_we_d;
        end
    end

    assign u_re      = u_re_q;
    assign u_we      = u_we_q;
    assign u_addr    = u_addr_q;
    assign u_wdata   = u_wdata_q;
    assign fill_data = fill_data_q;
    assign i_fill_we = i_fill_we_q;
    assign d_fill_we = d_fill_we_q;

    // Stall is combinational so a fresh miss freezes the pipe the same cycle.
    assign stall = i_miss_s | d_miss_s | (state_q != IDLE);

    sat_counter #(.CNT_W(CNT_W)) u_i_miss_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (i_inc_s),
        .cnt_o (i_miss_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_d_miss_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (d_inc_s),
        .cnt_o (d_miss_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_wb_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (wb_inc_s),
        .cnt_o (wb_cnt)
    );

endmodule

// File: tb/tb_dual_cache_miss_ctrl.sv
// Bench for dual_cache_miss_ctrl. Two instances share the request stimulus:
//   A: D_FIRST=1, WB_EN=1, CNT_W=16
//   B: D_FIRST=0, WB_EN=0, CNT_W=2
// Each has its own memory model (u_rdy 4 cycles after a request rises) and a
// cache model that raises the hit once the line for the current request has
// been filled.
module tb_dual_cache_miss_ctrl;

    typedef struct packed {
        logic [1:0]  kind;
        logic [13:0] addr;
        logic [63:0] data;
    } sb_t;

    localparam logic [1:0] K_WB = 2'd0;
    localparam logic [1:0] K_RD = 2'd1;
    localparam logic [1:0] K_IF = 2'd2;
    localparam logic [1:0] K_DF = 2'd3;

    logic        clk;
    logic        rst_n;
    logic        i_req, d_req, d_dirty;
    logic [13:0] i_line_addr, d_line_addr, d_victim_addr;
    logic [63:0] d_victim_data;
    logic [63:0] rdata_base;

    logic        i_hit_a, d_hit_a, i_hit_b, d_hit_b;
    logic        u_rdy_a, u_rdy_b;
    logic [63:0] u_rdata_a, u_rdata_b;
    logic        u_re_a, u_we_a, u_re_b, u_we_b;
    logic [13:0] u_addr_a, u_addr_b;
    logic [63:0] u_wdata_a, u_wdata_b, fill_data_a, fill_data_b;
    logic        i_fill_we_a, d_fill_we_a, i_fill_we_b, d_fill_we_b;
    logic        stall_a, stall_b;
    logic [15:0] i_miss_cnt_a, d_miss_cnt_a, wb_cnt_a;
    logic [1:0]  i_miss_cnt_b, d_miss_cnt_b, wb_cnt_b;

    int unsigned i_req_id, d_req_id;
    int unsigned i_fill_id_a, d_fill_id_a, i_fill_id_b, d_fill_id_b;
    int          cnt_a, cnt_b;
    int          cyc, rel_cyc, fill_cyc_a;
    int          total, bad;
    logic        prev_fill_a, prev_fill_b;

    sb_t         exp_a[$];
    sb_t         exp_b[$];
    string       dq_name[$];
    logic [63:0] dq_act[$];
    logic [63:0] dq_exp[$];

    assign i_hit_a   = (i_fill_id_a == i_req_id);
    assign d_hit_a   = (d_fill_id_a == d_req_id);
    assign i_hit_b   = (i_fill_id_b == i_req_id);
    assign d_hit_b   = (d_fill_id_b == d_req_id);
    assign u_rdata_a = rdata_base ^ {50'd0, u_addr_a};
    assign u_rdata_b = rdata_base ^ {50'd0, u_addr_b};

    dual_cache_miss_ctrl #(.ADDR_W(14), .LINE_W(64), .CNT_W(16), .D_FIRST(1), .WB_EN(1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_hit(i_hit_a), .i_line_addr(i_line_addr),
        .d_req(d_req), .d_hit(d_hit_a), .d_dirty(d_dirty), .d_line_addr(d_line_addr),
        .d_victim_addr(d_victim_addr), .d_victim_data(d_victim_data),
        .u_rdata(u_rdata_a), .u_rdy(u_rdy_a),
        .u_re(u_re_a), .u_we(u_we_a), .u_addr(u_addr_a), .u_wdata(u_wdata_a),
        .fill_data(fill_data_a), .i_fill_we(i_fill_we_a), .d_fill_we(d_fill_we_a),
        .stall(stall_a), .i_miss_cnt(i_miss_cnt_a), .d_miss_cnt(d_miss_cnt_a), .wb_cnt(wb_cnt_a)
    );

    dual_cache_miss_ctrl #(.ADDR_W(14), .LINE_W(64), .CNT_W(2), .D_FIRST(0), .WB_EN(0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_hit(i_hit_b), .i_line_addr(i_line_addr),
        .d_req(d_req), .d_hit(d_hit_b), .d_dirty(d_dirty), .d_line_addr(d_line_addr),
        .d_victim_addr(d_victim_addr), .d_victim_data(d_victim_data),
        .u_rdata(u_rdata_b), .u_rdy(u_rdy_b),
        .u_re(u_re_b), .u_we(u_we_b), .u_addr(u_addr_b), .u_wdata(u_wdata_b),
        .fill_data(fill_data_b), .i_fill_we(i_fill_we_b), .d_fill_we(d_fill_we_b),
        .stall(stall_b), .i_miss_cnt(i_miss_cnt_b), .d_miss_cnt(d_miss_cnt_b), .wb_cnt(wb_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory models: u_rdy pulses on the 4th cycle an op has been held.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            cnt_a = 0; u_rdy_a = 1'b0;
            cnt_b = 0; u_rdy_b = 1'b0;
        end else begin
            if (u_rdy_a) begin u_rdy_a = 1'b0; cnt_a = 0; end
            if (u_re_a || u_we_a) begin
                cnt_a = cnt_a + 1;
                if (cnt_a == 4) begin u_rdy_a = 1'b1; cnt_a = 0; end
            end
            if (u_rdy_b) begin u_rdy_b = 1'b0; cnt_b = 0; end
            if (u_re_b || u_we_b) begin
                cnt_b = cnt_b + 1;
                if (cnt_b == 4) begin u_rdy_b = 1'b1; cnt_b = 0; end
            end
        end
    end

    // Cache models: a fill of a side makes the current request of that side hit.
    always @(negedge clk) begin
        if (i_fill_we_a) i_fill_id_a = i_req_id;
        if (d_fill_we_a) d_fill_id_a = d_req_id;
        if (i_fill_we_b) i_fill_id_b = i_req_id;
        if (d_fill_we_b) d_fill_id_b = d_req_id;
    end

    task automatic cmp(input string n, input logic [79:0] act, input logic [79:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask

    task automatic unexpected(input string n, input sb_t obs);
        total = total + 1;
        bad   = bad + 1;
        $display("FAIL %s: got unexpected %h want nothing", n, obs);
    endtask

    // Monitor / scoreboard: the only process that steps total and bad.
    always @(negedge clk) begin
        sb_t obs;
        sb_t e;
        bit  have;
        while (dq_name.size() > 0) begin
            cmp(dq_name.pop_front(), {16'd0, dq_act.pop_front()}, {16'd0, dq_exp.pop_front()});
        end
        if (rst_n) begin
            // DUT A
            have = 1'b1;
            if (u_rdy_a && u_we_a)      obs = {K_WB, u_addr_a, u_wdata_a};
            else if (u_rdy_a && u_re_a) obs = {K_RD, u_addr_a, 64'd0};
            else if (i_fill_we_a)       obs = {K_IF, 14'd0, fill_data_a};
            else if (d_fill_we_a)       obs = {K_DF, 14'd0, fill_data_a};
            else                        have = 1'b0;
            if (u_re_a || u_we_a || i_fill_we_a || d_fill_we_a)
                cmp("A_excl", {78'd0, u_re_a & u_we_a, i_fill_we_a & d_fill_we_a}, 80'd0);
            if (i_fill_we_a || d_fill_we_a) begin
                cmp("A_fill_width", {79'd0, prev_fill_a}, 80'd0);
                fill_cyc_a = cyc;
            end
            if (have) begin
                if (exp_a.size() == 0) unexpected("A_sb", obs);
                else begin e = exp_a.pop_front(); cmp("A_sb", obs, e); end
            end
            // DUT B
            have = 1'b1;
            if (u_rdy_b && u_we_b)      obs = {K_WB, u_addr_b, u_wdata_b};
            else if (u_rdy_b && u_re_b) obs = {K_RD, u_addr_b, 64'd0};
            else if (i_fill_we_b)       obs = {K_IF, 14'd0, fill_data_b};
            else if (d_fill_we_b)       obs = {K_DF, 14'd0, fill_data_b};
            else                        have = 1'b0;
            if (u_re_b || u_we_b || i_fill_we_b || d_fill_we_b)
                cmp("B_excl", {78'd0, u_re_b & u_we_b, i_fill_we_b & d_fill_we_b}, 80'd0);
            if (i_fill_we_b || d_fill_we_b)
                cmp("B_fill_width", {79'd0, prev_fill_b}, 80'd0);
            if (have) begin
                if (exp_b.size() == 0) unexpected("B_sb", obs);
                else begin e = exp_b.pop_front(); cmp("B_sb", obs, e); end
            end
        end
        prev_fill_a = i_fill_we_a | d_fill_we_a;
        prev_fill_b = i_fill_we_b | d_fill_we_b;
    end

    // Direct check: queued here, compared by the monitor.
    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        dq_name.push_back(n);
        dq_act.push_back(act);
        dq_exp.push_back(exp);
    endtask

    function automatic logic [63:0] fdat(input logic [13:0] a);
        return rdata_base ^ {50'd0, a};
    endfunction

    task automatic push_a(input logic [1:0] k, input logic [13:0] a, input logic [63:0] d);
        exp_a.push_back({k, a, d});
    endtask

    task automatic push_b(input logic [1:0] k, input logic [13:0] a, input logic [63:0] d);
        exp_b.push_back({k, a, d});
    endtask

    task automatic wait_idle(input string n);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (!stall_a && !stall_b) begin ok = 1'b1; break; end
        end
        chk(n, {63'd0, ok}, 64'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        i_req = 1'b0; d_req = 1'b0; d_dirty = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic issue_i(input logic [13:0] a);
        i_line_addr = a;
        i_req_id    = i_req_id + 1;
        i_req       = 1'b1;
    endtask

    task automatic issue_d(input logic [13:0] a, input logic dirty, input logic [13:0] va, input logic [63:0] vd);
        d_line_addr   = a;
        d_dirty       = dirty;
        d_victim_addr = va;
        d_victim_data = vd;
        d_req_id      = d_req_id + 1;
        d_req         = 1'b1;
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0; fill_cyc_a = 0; rel_cyc = 0;
        prev_fill_a = 1'b0; prev_fill_b = 1'b0;
        i_fill_id_a = 0; d_fill_id_a = 0; i_fill_id_b = 0; d_fill_id_b = 0;
        i_req_id = 0; d_req_id = 0;
        u_rdy_a = 1'b0; u_rdy_b = 1'b0; cnt_a = 0; cnt_b = 0;
        rdata_base = 64'hA5A5_0000_1234_0000;
        d_req = 1'b0; d_dirty = 1'b0;
        d_line_addr = 14'h0000; d_victim_addr = 14'h0000; d_victim_data = 64'd0;
        rst_n = 1'b0;

        // 1. Miss pending through reset, first read, fill timing.
        issue_i(14'h0040);
        push_a(K_RD, 14'h0040, 64'd0); push_a(K_IF, 14'h0000, fdat(14'h0040));
        push_b(K_RD, 14'h0040, 64'd0); push_b(K_IF, 14'h0000, fdat(14'h0040));
        @(negedge clk);
        chk("t1_rst_req",   {62'd0, u_re_a, u_we_a}, 64'd0);
        chk("t1_rst_fill",  {62'd0, i_fill_we_a, d_fill_we_a}, 64'd0);
        chk("t1_rst_fdata", fill_data_a, 64'd0);
        chk("t1_rst_addr",  {50'd0, u_addr_a}, 64'd0);
        chk("t1_rst_cnt",   {16'd0, i_miss_cnt_a, d_miss_cnt_a, wb_cnt_a}, 64'd0);
        chk("t1_rst_stall", {63'd0, stall_a}, 64'd1);
        rst_n = 1'b1;
        rel_cyc = cyc;
        @(negedge clk);
        chk("t1_u_re",   {62'd0, u_re_a, u_we_a}, 64'd2);
        chk("t1_u_addr", {50'd0, u_addr_a}, 64'h0040);
        wait_idle("t1_idle");
        chk("t1_fill_lat", 64'(fill_cyc_a - rel_cyc), 64'd5);
        chk("t1_icnt_a", {48'd0, i_miss_cnt_a}, 64'd1);
        chk("t1_icnt_b", {62'd0, i_miss_cnt_b}, 64'd1);
        i_req = 1'b0;

        // 2. Dirty D miss: writeback on A, skipped on B (WB_EN=0).
        do_reset();
        issue_d(14'h0456, 1'b1, 14'h0123, 64'hDEAD_BEEF_0000_0001);
        push_a(K_WB, 14'h0123, 64'hDEAD_BEEF_0000_0001);
        push_a(K_RD, 14'h0456, 64'd0); push_a(K_DF, 14'h0000, fdat(14'h0456));
        push_b(K_RD, 14'h0456, 64'd0); push_b(K_DF, 14'h0000, fdat(14'h0456));
        wait_idle("t2_idle");
        chk("t2_wb_a",   {48'd0, wb_cnt_a}, 64'd1);
        chk("t2_wb_b",   {62'd0, wb_cnt_b}, 64'd0);
        chk("t2_dcnt_a", {48'd0, d_miss_cnt_a}, 64'd1);
        d_req = 1'b0; d_dirty = 1'b0;

        // 3. Simultaneous misses: A serves D first, B serves I first.
        do_reset();
        rdata_base = 64'h0F0F_1111_2222_3333;
        issue_i(14'h0100);
        issue_d(14'h0200, 1'b0, 14'h0000, 64'd0);
        push_a(K_RD, 14'h0200, 64'd0); push_a(K_DF, 14'h0000, fdat(14'h0200));
        push_a(K_RD, 14'h0100, 64'd0); push_a(K_IF, 14'h0000, fdat(14'h0100));
        push_b(K_RD, 14'h0100, 64'd0); push_b(K_IF, 14'h0000, fdat(14'h0100));
        push_b(K_RD, 14'h0200, 64'd0); push_b(K_DF, 14'h0000, fdat(14'h0200));
        wait_idle("t3_idle");
        chk("t3_cnt_a", {32'd0, i_miss_cnt_a, d_miss_cnt_a}, {32'd0, 16'd1, 16'd1});
        chk("t3_cnt_b", {60'd0, i_miss_cnt_b, d_miss_cnt_b}, {60'd0, 2'd1, 2'd1});
        i_req = 1'b0; d_req = 1'b0;

        // 3b. Both sides on the same line: two separate reads.
        @(negedge clk);
        issue_i(14'h0300);
        issue_d(14'h0300, 1'b0, 14'h0000, 64'd0);
        push_a(K_RD, 14'h0300, 64'd0); push_a(K_DF, 14'h0000, fdat(14'h0300));
        push_a(K_RD, 14'h0300, 64'd0); push_a(K_IF, 14'h0000, fdat(14'h0300));
        push_b(K_RD, 14'h0300, 64'd0); push_b(K_IF, 14'h0000, fdat(14'h0300));
        push_b(K_RD, 14'h0300, 64'd0); push_b(K_DF, 14'h0000, fdat(14'h0300));
        wait_idle("t3b_idle");
        i_req = 1'b0; d_req = 1'b0;

        // 4. Clean miss with a known data word; stall falls once hit.
        do_reset();
        rdata_base = 64'h0011_2233_4455_6677;
        issue_i(14'h0000);
        push_a(K_RD, 14'h0000, 64'd0); push_a(K_IF, 14'h0000, 64'h0011_2233_4455_6677);
        push_b(K_RD, 14'h0000, 64'd0); push_b(K_IF, 14'h0000, 64'h0011_2233_4455_6677);
        wait_idle("t4_idle");
        chk("t4_fill_data", fill_data_a, 64'h0011_2233_4455_6677);
        chk("t4_stall", {62'd0, stall_a, stall_b}, 64'd0);
        i_req = 1'b0;

        // 5. Five I misses: A counts 5, B saturates at 3.
        do_reset();
        for (int n = 0; n < 5; n++) begin
            issue_i(14'h0010 + 14'(n));
            push_a(K_RD, 14'h0010 + 14'(n), 64'd0); push_a(K_IF, 14'h0000, fdat(14'h0010 + 14'(n)));
            push_b(K_RD, 14'h0010 + 14'(n), 64'd0); push_b(K_IF, 14'h0000, fdat(14'h0010 + 14'(n)));
            wait_idle("t5_idle");
            i_req = 1'b0;
            @(negedge clk);
        end
        chk("t5_icnt_a", {48'd0, i_miss_cnt_a}, 64'd5);
        chk("t5_icnt_b", {62'd0, i_miss_cnt_b}, 64'd3);

        // 7. Request dropped mid-service: the fill still happens.
        do_reset();
        issue_d(14'h0555, 1'b0, 14'h0000, 64'd0);
        push_a(K_RD, 14'h0555, 64'd0); push_a(K_DF, 14'h0000, fdat(14'h0555));
        push_b(K_RD, 14'h0555, 64'd0); push_b(K_DF, 14'h0000, fdat(14'h0555));
        @(negedge clk);
        @(negedge clk);
        d_req = 1'b0;
        wait_idle("t7_idle");
        repeat (2) @(negedge clk);
        chk("t7_dcnt_a", {48'd0, d_miss_cnt_a}, 64'd1);

        // 6. Reset during RD: op abandoned, no fill, everything cleared.
        do_reset();
        issue_i(14'h0777);
        repeat (3) @(negedge clk);
        chk("t6_in_rd", {62'd0, u_re_a, u_re_b}, 64'd3);
        rst_n = 1'b0;
        i_req = 1'b0;
        @(negedge clk);
        chk("t6_u_re",  {62'd0, u_re_a, u_re_b}, 64'd0);
        chk("t6_cnt_a", {16'd0, i_miss_cnt_a, d_miss_cnt_a, wb_cnt_a}, 64'd0);
        chk("t6_cnt_b", {58'd0, i_miss_cnt_b, d_miss_cnt_b, wb_cnt_b}, 64'd0);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("t6_idle", {62'd0, stall_a, stall_b}, 64'd0);

        repeat (2) @(negedge clk);
        chk("sb_a_drained", 64'(exp_a.size()), 64'd0);
        chk("sb_b_drained", 64'(exp_b.size()), 64'd0);
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
